sync_delay_prog: RTL and testbench

SYNC_DELAY_PROG -- requirements
Module: sync_delay_prog

---
 rtl/sync_delay_pkg.sv | 28 ++
 rtl/delay_ram.sv | 38 +++
 rtl/sync_delay_prog.sv | 198 +++++++++++++++++++
 tb/tb_sync_delay_prog.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/sync_delay_pkg.sv
// -----------------------------------------------------------------------------
// sync_delay_pkg
//   Shared definitions for the programmable synchronous delay line.
//   - state_t : FSM state encoding (IDLE=0, FILL=1, RUN=2)
//   - clog2() : ceiling log2, usable in parameter declarations
// -----------------------------------------------------------------------------
package sync_delay_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } state_t;

    // Number of bits needed to address 'value' distinct items (minimum 1).
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        if (result == 0) begin
            result = 1;
        end
        return result;
    endfunction

endpackage : sync_delay_pkg

// File: rtl/delay_ram.sv
// -----------------------------------------------------------------------------
// delay_ram
//   Simple dual-port storage for the delay line: one synchronous write port,
//   one asynchronous (combinational) read port. No reset: the contents are
//   masked by the controller's fill phase until they hold fresh data.
//
// Ports
//   clk    : write clock
//   we     : write enable
//   waddr  : write address
//   wdata  : write data
//   raddr  : read address
//   rdata  : read data (combinational from raddr)
// -----------------------------------------------------------------------------
module delay_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 33,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule : delay_ram

// File: rtl/sync_delay_prog.sv
// -----------------------------------------------------------------------------
// sync_delay_prog
//   Programmable delay line. Every enabled clock edge captures {din_valid, din}
//   into a circular buffer; the word captured on enabled edge t is presented
//   on dout after enabled edge t+D-1 (D=1 is a plain register stage).
//   The requested delay is clamped to 1..MAX_DELAY (out-of-range requests set
//   the sticky delay_err). Any change of the applied delay restarts a fill
//   phase during which dout_valid and ready are held low, so words written
//   under an older delay (or stale memory after reset) are never flagged valid.
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   en         : clock enable; when low nothing advances
//   delay      : requested delay in enabled cycles
//   din        : input data word
//   din_valid  : qualifier for din
//   dout       : delayed data (registered)
//   dout_valid : delayed din_valid, forced low outside RUN (registered)
//   ready      : high only while in RUN (registered)
//   delay_err  : sticky out-of-range delay flag, cleared by reset only
// -----------------------------------------------------------------------------
module sync_delay_prog
    import sync_delay_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int MAX_DELAY   = 16,
    parameter int DELAY_WIDTH = clog2(MAX_DELAY + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic [DELAY_WIDTH-1:0] delay,
    input  logic [DATA_WIDTH-1:0]  din,
    input  logic                   din_valid,
    output logic [DATA_WIDTH-1:0]  dout,
    output logic                   dout_valid,
    output logic                   ready,
    output logic                   delay_err
);

    localparam int PTR_W  = clog2(MAX_DELAY);
    localparam int WORD_W = DATA_WIDTH + 1;

    localparam logic [DELAY_WIDTH-1:0] DA_ONE = DELAY_WIDTH'(1);
    localparam logic [DELAY_WIDTH-1:0] DA_MAX = DELAY_WIDTH'(MAX_DELAY);
    localparam logic [PTR_W-1:0]       PTR_LAST = PTR_W'(MAX_DELAY - 1);

    // -------------------------------------------------------------------------
    // Delay clamp helpers
    // -------------------------------------------------------------------------
    function automatic logic delay_out_of_range(input logic [DELAY_WIDTH-1:0] d);
        return (d == '0) || (int'(d) > MAX_DELAY);
    endfunction

    function automatic logic [DELAY_WIDTH-1:0] clamp_delay(input logic [DELAY_WIDTH-1:0] d);
        logic [DELAY_WIDTH-1:0] r;
        if (d == '0) begin
            r = DA_ONE;
        end else if (int'(d) > MAX_DELAY) begin
            r = DA_MAX;
        end else begin
            r = d;
        end
        return r;
    endfunction

    // -------------------------------------------------------------------------
    // Control state
    // -------------------------------------------------------------------------
    state_t                 state;
    logic [PTR_W-1:0]       wr_ptr;
    logic [DELAY_WIDTH-1:0] fill_cnt;
    logic [DELAY_WIDTH-1:0] da;

    // -------------------------------------------------------------------------
    // Combinational helpers
    // -------------------------------------------------------------------------
    logic [DELAY_WIDTH-1:0] da_clamped;
    logic                   delay_bad;
    logic                   da_change;
    logic [PTR_W-1:0]       wr_ptr_nxt;
    logic [PTR_W-1:0]       rd_addr;
    logic [DELAY_WIDTH-1:0] fill_nxt;
    logic                   fill_done;
    logic [WORD_W-1:0]      wr_word;
    logic [WORD_W-1:0]      ram_word;
    logic [WORD_W-1:0]      rd_word;

    assign da_clamped = clamp_delay(delay);
    assign delay_bad  = delay_out_of_range(delay);

    // IDLE always (re)loads; elsewhere only a different clamped delay does.
    assign da_change  = (state == IDLE) || (da_clamped != da);

    assign wr_ptr_nxt = (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);

    assign wr_word    = {din_valid, din};

    // Read the word written D-1 enabled edges ago. The clamped value is used
    // so that the address is already correct on the edge that loads a new Da.
    always_comb begin
        int rd_sum;
        rd_sum = int'(wr_ptr) + MAX_DELAY - (int'(da_clamped) - 1);
        if (rd_sum >= MAX_DELAY) begin
            rd_sum = rd_sum - MAX_DELAY;
        end
        rd_addr = PTR_W'(rd_sum);
    end

    // With D=1 the word is needed on the same edge it is written, which the
    // memory cannot provide yet, so it bypasses the buffer.
    assign rd_word = (da_clamped == DA_ONE) ? wr_word : ram_word;

    // The word taken on the loading edge is already the first of the Da words
    // in flight, so Da-1 further enabled edges complete the fill.
    assign fill_nxt  = fill_cnt + DELAY_WIDTH'(1);
    assign fill_done = (fill_nxt == (da - DA_ONE));

    // -------------------------------------------------------------------------
    // Circular buffer
    // -------------------------------------------------------------------------
    delay_ram #(
        .DEPTH (MAX_DELAY),
        .WIDTH (WORD_W),
        .AW    (PTR_W)
    ) u_ram (
        .clk   (clk),
        .we    (en),
        .waddr (wr_ptr),
        .wdata (wr_word),
        .raddr (rd_addr),
        .rdata (ram_word)
    );

    // -------------------------------------------------------------------------
    // FSM, pointers and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            fill_cnt   <= '0;
            da         <= DA_ONE;
            dout       <= '0;
            dout_valid <= 1'b0;
            ready      <= 1'b0;
            delay_err  <= 1'b0;
        end else if (en) begin
            wr_ptr <= wr_ptr_nxt;
            dout   <= rd_word[DATA_WIDTH-1:0];

            if (delay_bad) begin
                delay_err <= 1'b1;
            end

            if (da_change) begin
                da       <= da_clamped;
                fill_cnt <= '0;
                if (da_clamped == DA_ONE) begin
                    // A one-deep fill completes on the loading edge itself.
                    state      <= RUN;
                    ready      <= 1'b1;
                    dout_valid <= rd_word[DATA_WIDTH];
                end else begin
                    state      <= FILL;
                    ready      <= 1'b0;
                    dout_valid <= 1'b0;
                end
            end else begin
                case (state)
                    FILL: begin
                        fill_cnt <= fill_nxt;
                        if (fill_done) begin
                            state      <= RUN;
                            ready      <= 1'b1;
                            dout_valid <= rd_word[DATA_WIDTH];
                        end else begin
                            ready      <= 1'b0;
                            dout_valid <= 1'b0;
                        end
                    end
                    RUN: begin
                        ready      <= 1'b1;
                        dout_valid <= rd_word[DATA_WIDTH];
                    end
                    default: begin
                        // Unused encoding: fall back to IDLE, which reloads.
                        state      <= IDLE;
                        ready      <= 1'b0;
                        dout_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule : sync_delay_prog

// File: tb/tb_sync_delay_prog.sv
// -----------------------------------------------------------------------------
// tb_sync_delay_prog
//   Self-checking bench for sync_delay_prog (DATA_WIDTH=32, MAX_DELAY=16).
//   A table of phases drives the delay / enable / reset scenarios; a behavioural
//   model pushes each sampled word with the enabled-edge index at which it is
//   due onto a scoreboard queue, and the front entry is compared against the
//   DUT outputs when that edge arrives.
// -----------------------------------------------------------------------------
module tb_sync_delay_prog;

    localparam int DW   = 32;
    localparam int MAXD = 16;
    localparam int DLW  = 5;

    logic           clk;
    logic           rst_n;
    logic           en;
    logic [DLW-1:0] delay;
    logic [DW-1:0]  din;
    logic           din_valid;
    logic [DW-1:0]  dout;
    logic           dout_valid;
    logic           ready;
    logic           delay_err;

    sync_delay_prog #(
        .DATA_WIDTH  (DW),
        .MAX_DELAY   (MAXD),
        .DELAY_WIDTH (DLW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .delay      (delay),
        .din        (din),
        .din_valid  (din_valid),
        .dout       (dout),
        .dout_valid (dout_valid),
        .ready      (ready),
        .delay_err  (delay_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          vld;
        logic [DW-1:0] data;
        int            due;
    } sb_t;

    typedef struct {
        bit             rst;
        logic [DLW-1:0] d;
        int             n;
        bit             tog;
        bit             err;
        bit             rdy;
    } phase_t;

    int checks   = 0;
    int failures = 0;

    sb_t            sbq[$];
    int             n_edge;
    int             din_cnt;
    bit             m_idle;
    logic [DLW-1:0] m_da;
    int             m_vfrom;
    bit             m_err;
    bit             last_dv;
    bit             last_rdy;
    logic [DW-1:0]  last_d;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_idle   = 1'b1;
        m_da     = DLW'(1);
        m_vfrom  = 0;
        m_err    = 1'b0;
        last_dv  = 1'b0;
        last_rdy = 1'b0;
        last_d   = '0;
        sbq.delete();
    endtask

    // Reset asserted between edges; outputs must clear without waiting for clk.
    task automatic rst_pulse();
        @(negedge clk);
        en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_dout",       dout,               32'd0);
        chk("rst_dout_valid", 32'(dout_valid),    32'd0);
        chk("rst_ready",      32'(ready),         32'd0);
        chk("rst_delay_err",  32'(delay_err),     32'd0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic step(input logic [DLW-1:0] d, input bit e);
        logic [DLW-1:0] cd;
        sb_t            ent;
        bit             exp_dv;
        logic [DW-1:0]  exp_d;
        @(negedge clk);
        en = e;
        if (e) begin
            delay     = d;
            din       = DW'(din_cnt);
            din_valid = !(din_cnt > 20 && (din_cnt % 7) == 0);
            din_cnt++;
        end else begin
            delay     = d ^ DLW'(3);
            din       = $urandom;
            din_valid = 1'b1;
        end
        @(posedge clk);
        #1;
        if (e) begin
            n_edge++;
            if (d == '0) begin
                cd    = DLW'(1);
                m_err = 1'b1;
            end else if (int'(d) > MAXD) begin
                cd    = DLW'(MAXD);
                m_err = 1'b1;
            end else begin
                cd = d;
            end
            if (m_idle || cd != m_da) begin
                m_idle  = 1'b0;
                m_da    = cd;
                m_vfrom = n_edge + int'(cd) - 1;
                sbq.delete();
            end
            sbq.push_back('{vld: din_valid, data: din, due: n_edge + int'(m_da) - 1});
            exp_dv = 1'b0;
            exp_d  = last_d;
            if (sbq.size() > 0 && sbq[0].due == n_edge) begin
                ent    = sbq.pop_front();
                exp_dv = ent.vld;
                exp_d  = ent.data;
            end
            last_dv  = exp_dv;
            last_rdy = (n_edge >= m_vfrom);
            if (exp_dv) last_d = exp_d;
            chk($sformatf("dout_valid@%0d", n_edge), 32'(dout_valid), 32'(last_dv));
            chk($sformatf("ready@%0d", n_edge),      32'(ready),      32'(last_rdy));
            chk($sformatf("delay_err@%0d", n_edge),  32'(delay_err),  32'(m_err));
            if (exp_dv) chk($sformatf("dout@%0d", n_edge), dout, exp_d);
        end else begin
            chk("hold_dout_valid", 32'(dout_valid), 32'(last_dv));
            chk("hold_ready",      32'(ready),      32'(last_rdy));
            chk("hold_delay_err",  32'(delay_err),  32'(m_err));
            if (last_dv) chk("hold_dout", dout, last_d);
        end
    endtask

    phase_t ph[15];

    initial begin
        //            rst   delay   n   tog   err   rdy
        ph[0]  = '{1'b1, 5'd4,  12, 1'b0, 1'b0, 1'b1}; // D=4 from reset
        ph[1]  = '{1'b1, 5'd1,   6, 1'b0, 1'b0, 1'b1}; // D=1 from reset
        ph[2]  = '{1'b0, 5'd3,   8, 1'b0, 1'b0, 1'b1}; // run at D=3
        ph[3]  = '{1'b0, 5'd6,  10, 1'b0, 1'b0, 1'b1}; // switch 3 -> 6
        ph[4]  = '{1'b0, 5'd0,   6, 1'b0, 1'b1, 1'b1}; // delay=0 -> Da=1, err
        ph[5]  = '{1'b0, 5'd21, 20, 1'b0, 1'b1, 1'b1}; // MAX+5 -> Da=16
        ph[6]  = '{1'b0, 5'd16,  4, 1'b0, 1'b1, 1'b1}; // same clamped Da, err sticky
        ph[7]  = '{1'b1, 5'd5,  20, 1'b1, 1'b0, 1'b1}; // D=5, en toggling
        ph[8]  = '{1'b0, 5'd5,   8, 1'b0, 1'b0, 1'b1}; // steady RUN
        ph[9]  = '{1'b1, 5'd5,   8, 1'b0, 1'b0, 1'b1}; // reset mid-RUN
        ph[10] = '{1'b0, 5'd7,   3, 1'b0, 1'b0, 1'b0}; // start filling D=7
        ph[11] = '{1'b0, 5'd2,   5, 1'b0, 1'b0, 1'b1}; // change mid-fill
        ph[12] = '{1'b0, 5'd3,   2, 1'b0, 1'b0, 1'b0}; // fill D=3, one edge short
        ph[13] = '{1'b0, 5'd4,   2, 1'b0, 1'b0, 1'b0}; // change on completing edge
        ph[14] = '{1'b0, 5'd4,   4, 1'b0, 1'b0, 1'b1}; // D=4 completes

        rst_n     = 1'b0;
        en        = 1'b0;
        delay     = 5'd4;
        din       = '0;
        din_valid = 1'b0;
        n_edge    = 0;
        din_cnt   = 1;
        model_reset();

        repeat (2) @(negedge clk);
        chk("init_dout",       dout,            32'd0);
        chk("init_dout_valid", 32'(dout_valid), 32'd0);
        chk("init_ready",      32'(ready),      32'd0);
        chk("init_delay_err",  32'(delay_err),  32'd0);
        #2;
        rst_n = 1'b1;

        for (int p = 0; p < 15; p++) begin
            if (ph[p].rst) rst_pulse();
            for (int i = 0; i < ph[p].n; i++) begin
                step(ph[p].d, ph[p].tog ? ((i % 2) == 0) : 1'b1);
            end
            chk($sformatf("phase%0d_ready", p),     32'(ready),     32'(ph[p].rdy));
            chk($sformatf("phase%0d_delay_err", p), 32'(delay_err), 32'(ph[p].err));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_sync_delay_prog
